// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-classifier output stage:
//   NUM_CLASSES     - number of output neurons (one per digit class)
//   DEFAULT_COUNT_W - default width of a per-neuron spike count
//   WIN_CNT_W       - width of the inference-window cycle counter
//   state_t         - spike_count_bank FSM encoding
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int NUM_CLASSES     = 10;
    localparam int DEFAULT_COUNT_W = 8;
    localparam int WIN_CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : snn_pkg

// File: rtl/spike_counter.sv
// -----------------------------------------------------------------------------
// spike_counter
// One saturating spike counter. Clears to zero on clr, otherwise adds one on
// inc until it reaches its all-ones value, where it sticks.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (count -> 0)
//   clr    - synchronous clear, has priority over inc
//   inc    - count one spike this cycle
//   count  - registered count value
// -----------------------------------------------------------------------------
module spike_counter
    import snn_pkg::*;
#(
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [COUNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block evaluation order.
    // NOTE: the count is reset even though it is data, because downstream
    // logic may read it in IDLE right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != COUNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : spike_counter

// File: rtl/spike_count_bank.sv
// -----------------------------------------------------------------------------
// spike_count_bank
// Counts spikes from the ten output neurons over a window of WINDOW_CYCLES
// cycles, then offers the ten counts to the argmax stage on a valid/ready
// handshake. FSM: IDLE -> (start) -> COUNT -> (window done) -> DONE ->
// (count_ready) -> IDLE.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - begin a window (only looked at in IDLE)
//   spikes[9:0]       - one-cycle spike pulse per output neuron
//   count_ready       - consumer accepts the counts
//   busy              - window in progress (COUNT)
//   count_valid       - counts final and stable (DONE)
//   spike_count_0..9  - per-neuron saturating counts
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module spike_count_bank
    import snn_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100,
    parameter int COUNT_W       = DEFAULT_COUNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_CLASSES-1:0] spikes,
    input  logic                   count_ready,
    output logic                   busy,
    output logic                   count_valid,
    output logic [COUNT_W-1:0]     spike_count_0,
    output logic [COUNT_W-1:0]     spike_count_1,
    output logic [COUNT_W-1:0]     spike_count_2,
    output logic [COUNT_W-1:0]     spike_count_3,
    output logic [COUNT_W-1:0]     spike_count_4,
    output logic [COUNT_W-1:0]     spike_count_5,
    output logic [COUNT_W-1:0]     spike_count_6,
    output logic [COUNT_W-1:0]     spike_count_7,
    output logic [COUNT_W-1:0]     spike_count_8,
    output logic [COUNT_W-1:0]     spike_count_9
);

    // Window counter value during the last sampling cycle of a window.
    localparam logic [WIN_CNT_W-1:0] LAST_CYCLE = WIN_CNT_W'(WINDOW_CYCLES - 1);

    state_t                 r_state;
    logic [WIN_CNT_W-1:0]   r_win_cnt;
    logic                   r_busy;
    logic                   r_count_valid;

    logic                   w_clr;
    logic [NUM_CLASSES-1:0] w_inc;
    logic [COUNT_W-1:0]     w_count [NUM_CLASSES];

    // Counts are cleared on the accepted start, so the previous window's
    // result stays readable for as long as the block sits in IDLE.
    assign w_clr = (r_state == IDLE) && start;
    // Spikes only count while in COUNT; DONE freezes the result.
    assign w_inc = (r_state == COUNT) ? spikes : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_win_cnt     <= '0;
            r_busy        <= 1'b0;
            r_count_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= COUNT;
                        r_win_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                COUNT: begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    // This cycle's spikes are still counted; leave afterwards.
                    if (r_win_cnt == LAST_CYCLE) begin
                        r_state       <= DONE;
                        r_busy        <= 1'b0;
                        r_count_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here, even alongside ready.
                    if (count_ready) begin
                        r_state       <= IDLE;
                        r_count_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_busy        <= 1'b0;
                    r_count_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_counter
        spike_counter #(
            .COUNT_W (COUNT_W)
        ) u_counter (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (w_clr),
            .inc   (w_inc[g]),
            .count (w_count[g])
        );
    end

    assign busy          = r_busy;
    assign count_valid   = r_count_valid;
    assign spike_count_0 = w_count[0];
    assign spike_count_1 = w_count[1];
    assign spike_count_2 = w_count[2];
    assign spike_count_3 = w_count[3];
    assign spike_count_4 = w_count[4];
    assign spike_count_5 = w_count[5];
    assign spike_count_6 = w_count[6];
    assign spike_count_7 = w_count[7];
    assign spike_count_8 = w_count[8];
    assign spike_count_9 = w_count[9];

endmodule : spike_count_bank

// File: tb/tb_spike_count_bank.sv
// -----------------------------------------------------------------------------
// tb_spike_count_bank
// Two instances: a 16-cycle window and a 300-cycle window. A table of windows
// (spike pattern, handshake behaviour, expected counts) is played through the
// selected instance; expected counts go on a scoreboard queue when the window
// is started and are popped when count_valid appears. Reset behaviour is
// exercised by hand-written sequences. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spike_count_bank;

    logic clk;
    logic rst_n;
    logic start_drv;
    logic sel;
    logic [9:0] spikes_drv;
    logic ready_drv;

    wire start16  = start_drv & ~sel;
    wire start300 = start_drv & sel;

    wire             busy16,  valid16;
    wire             busy300, valid300;
    wire [9:0][7:0]  cnt16;
    wire [9:0][7:0]  cnt300;

    wire             obs_busy   = sel ? busy300  : busy16;
    wire             obs_valid  = sel ? valid300 : valid16;
    wire [9:0][7:0]  obs_counts = sel ? cnt300   : cnt16;

    int n_tests = 0;
    int n_fail  = 0;

    logic [79:0] sb_q [$];

    typedef struct {
        logic        sel;          // 0: 16-cycle instance, 1: 300-cycle instance
        int          win;          // window length of that instance
        logic [9:0]  hold;         // lines high every sampling cycle
        logic [9:0]  alt;          // lines high on odd cycles 1,3,5,...
        int          mid_start;    // cycle to pulse start inside COUNT (0: none)
        int          ready_hold;   // DONE cycles with ready low (start held high)
        logic        start_w_ready;// assert start together with ready
        logic [79:0] exp;          // expected counts, {c9,...,c0}
    } vec_t;

    vec_t vecs [8];

    spike_count_bank #(.WINDOW_CYCLES(16), .COUNT_W(8)) dut16 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start16),
        .spikes        (spikes_drv),
        .count_ready   (ready_drv),
        .busy          (busy16),
        .count_valid   (valid16),
        .spike_count_0 (cnt16[0]),
        .spike_count_1 (cnt16[1]),
        .spike_count_2 (cnt16[2]),
        .spike_count_3 (cnt16[3]),
        .spike_count_4 (cnt16[4]),
        .spike_count_5 (cnt16[5]),
        .spike_count_6 (cnt16[6]),
        .spike_count_7 (cnt16[7]),
        .spike_count_8 (cnt16[8]),
        .spike_count_9 (cnt16[9])
    );

    spike_count_bank #(.WINDOW_CYCLES(300), .COUNT_W(8)) dut300 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start300),
        .spikes        (spikes_drv),
        .count_ready   (ready_drv),
        .busy          (busy300),
        .count_valid   (valid300),
        .spike_count_0 (cnt300[0]),
        .spike_count_1 (cnt300[1]),
        .spike_count_2 (cnt300[2]),
        .spike_count_3 (cnt300[3]),
        .spike_count_4 (cnt300[4]),
        .spike_count_5 (cnt300[5]),
        .spike_count_6 (cnt300[6]),
        .spike_count_7 (cnt300[7]),
        .spike_count_8 (cnt300[8]),
        .spike_count_9 (cnt300[9])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish within 1 ms");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered on a falling edge with the selected instance in IDLE; starts the
    // window immediately so back-to-back windows run at the minimum period.
    task automatic run_vec(input vec_t v);
        logic [79:0] exp_q;
        bit          seen;
        exp_q = '0;
        seen  = 1'b0;

        sel        = v.sel;
        start_drv  = 1'b1;
        ready_drv  = 1'b0;
        spikes_drv = 10'($urandom);
        sb_q.push_back(v.exp);

        for (int cyc = 1; cyc <= v.win + 4 && !seen; cyc++) begin
            @(negedge clk);
            start_drv = (cyc == v.mid_start);
            if (cyc <= v.win)
                spikes_drv = v.hold | ((cyc % 2 == 1) ? v.alt : 10'd0);
            else
                spikes_drv = 10'($urandom);
            if (cyc == 1)
                check("cleared_at_start", obs_counts, 80'd0);
            if (obs_valid) begin
                seen = 1'b1;
                check("valid_first_cycle", 80'(cyc), 80'(v.win + 1));
                check("busy_in_done", 80'(obs_busy), 80'd0);
                exp_q = sb_q.pop_front();
                check("final_counts", obs_counts, exp_q);
            end else begin
                check("busy_in_window", 80'(obs_busy), 80'(cyc <= v.win));
            end
        end

        if (!seen) begin
            check("valid_timeout", 80'd0, 80'd1);
            if (sb_q.size() > 0) exp_q = sb_q.pop_front();
        end

        for (int k = 0; k < v.ready_hold; k++) begin
            ready_drv  = 1'b0;
            start_drv  = 1'b1;
            spikes_drv = 10'($urandom);
            @(negedge clk);
            check("done_hold_valid", 80'(obs_valid), 80'd1);
            check("done_hold_counts", obs_counts, exp_q);
        end

        ready_drv = 1'b1;
        start_drv = v.start_w_ready;
        @(negedge clk);
        ready_drv = 1'b0;
        start_drv = 1'b0;
        check("post_hs_valid", 80'(obs_valid), 80'd0);
        check("post_hs_busy", 80'(obs_busy), 80'd0);
        check("post_hs_counts", obs_counts, exp_q);
    endtask

    initial begin
        vecs[0] = '{1'b0, 16,  10'h008, 10'h000, 0, 0, 1'b0, 80'h00_00_00_00_00_00_10_00_00_00};
        vecs[1] = '{1'b0, 16,  10'h000, 10'h080, 8, 5, 1'b0, 80'h00_00_08_00_00_00_00_00_00_00};
        vecs[2] = '{1'b0, 16,  10'h3FF, 10'h000, 0, 2, 1'b1, 80'h10_10_10_10_10_10_10_10_10_10};
        vecs[3] = '{1'b0, 16,  10'h001, 10'h002, 0, 0, 1'b0, 80'h00_00_00_00_00_00_00_00_08_10};
        vecs[4] = '{1'b0, 16,  10'h000, 10'h000, 0, 1, 1'b0, 80'h00_00_00_00_00_00_00_00_00_00};
        vecs[5] = '{1'b0, 16,  10'h200, 10'h0F0, 3, 0, 1'b1, 80'h10_00_08_08_08_08_00_00_00_00};
        vecs[6] = '{1'b1, 300, 10'h3FF, 10'h000, 0, 0, 1'b0, 80'hFF_FF_FF_FF_FF_FF_FF_FF_FF_FF};
        vecs[7] = '{1'b1, 300, 10'h000, 10'h020, 0, 0, 1'b0, 80'h00_00_00_00_96_00_00_00_00_00};

        rst_n      = 1'b0;
        start_drv  = 1'b0;
        ready_drv  = 1'b0;
        sel        = 1'b0;
        spikes_drv = '0;

        // Reset with random spike activity, then three quiet cycles after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spikes_drv = 10'($urandom);
            check("rst_busy", 80'({busy16, busy300}), 80'd0);
            check("rst_valid", 80'({valid16, valid300}), 80'd0);
            check("rst_counts16", cnt16, 80'd0);
            check("rst_counts300", cnt300, 80'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spikes_drv = 10'($urandom);
            check("idle_busy", 80'({busy16, busy300}), 80'd0);
            check("idle_valid", 80'({valid16, valid300}), 80'd0);
            check("idle_counts", {cnt16 | cnt300}, 80'd0);
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a 16-cycle window with spikes[0] held high.
        sel        = 1'b0;
        start_drv  = 1'b1;
        spikes_drv = 10'h001;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start_drv = 1'b0;
        end
        check("pre_reset_count0", cnt16, 80'd7);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 80'(busy16), 80'd0);
        check("midrst_valid", 80'(valid16), 80'd0);
        check("midrst_counts", cnt16, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_idle", 80'({busy16, valid16}), 80'd0);
        run_vec('{1'b0, 16, 10'h001, 10'h000, 0, 0, 1'b0, 80'h00_00_00_00_00_00_00_00_00_10});

        check("scoreboard_empty", 80'(sb_q.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spike_count_bank

// File: doc/spike_count_bank.md
# spike_count_bank

Counts output-layer spikes from the ten classifier neurons over a fixed inference window. At the end of the window it presents ten 8-bit spike counts to the downstream argmax (max-spike) stage through a valid/ready handshake. It sits between the output neuron layer and the digit-prediction logic, and it is the producer end of the spike-count interface.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 100: number of cycles sampled per inference window; legal range 1..65535.
- `COUNT_W`, default 8: width of each spike count.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a new window; honoured only in IDLE.
- `spikes`, input, 10: bit i is a one-cycle spike from output neuron i.
- `count_ready`, input, 1: consumer has taken the counts.
- `busy`, output, 1: high in COUNT.
- `count_valid`, output, 1: high in DONE; counts are stable.
- `spike_count_0` … `spike_count_9`, output, COUNT_W each: per-neuron counts.

## Operation
- FSM states: IDLE, COUNT, DONE. Reset state is IDLE.
- IDLE, `start`=1: clear all ten counts and the window counter, then go to COUNT.
- IDLE, `start`=0: hold. Counts from the previous window remain readable.
- COUNT:
  - Each cycle, every count i with `spikes[i]`=1 increments by 1.
  - Counts saturate at 2^COUNT_W−1 (255) and never wrap.
  - The window counter (16-bit) increments every COUNT cycle.
  - In the cycle where the window counter equals WINDOW_CYCLES−1, that cycle's spikes are still counted and the FSM goes to DONE.
  - `start` is ignored.
- DONE:
  - Counts are frozen and `spikes` is ignored.
  - `count_valid`=1 until a cycle with `count_ready`=1, then go to IDLE.
  - `start` in DONE is ignored, including when it coincides with `count_ready`.
- Exactly WINDOW_CYCLES spike samples are taken per window.
- Simultaneous spikes on all ten lines in one cycle: each count increments independently.
- Reset mid-operation: asynchronously forces IDLE, zeroes all counts, and clears the window counter. The partial window is discarded.

## Timing
- Reset values: `busy`=0, `count_valid`=0, all `spike_count_*`=0.
- Define cycle 0 as the cycle in which `start` is sampled high in IDLE. Then:
  - COUNT occupies cycles 1..WINDOW_CYCLES. Spikes are sampled on those edges only.
  - `busy` is high for cycles 1..WINDOW_CYCLES.
  - `count_valid` first rises in cycle WINDOW_CYCLES+1.
  - The final counts are visible in that same cycle.
- Handshake completes on the rising edge with `count_valid`=1 and `count_ready`=1. `count_valid` is low the following cycle.
- Minimum start-to-start period: WINDOW_CYCLES+2 cycles. This assumes `count_ready` is tied high and `start` is reasserted in the first IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `snn_pkg` holds:
  - `NUM_CLASSES` = 10
  - default `COUNT_W` = 8
  - the FSM state encoding (IDLE=0, COUNT=1, DONE=2, 2 bits).
- Sub-module `spike_counter`: one COUNT_W saturating counter with `clr` and `inc` inputs, instantiated ten times.
- The top level contains the FSM, the 16-bit window counter, and the handshake.

## Test plan
1. Reset: drive `rst_n`=0 with random `spikes` → `busy`=0, `count_valid`=0, and all counts 0. Hold for 3 cycles after release → all outputs unchanged.
2. WINDOW_CYCLES=16; `spikes[3]`=1 every cycle, others 0; pulse `start` → `count_valid` rises on cycle 17, `spike_count_3`=16, all other counts 0, `busy` high cycles 1..16.
3. WINDOW_CYCLES=300; all ten spike lines high → every count is 255, with no wrap.
4. WINDOW_CYCLES=16; `spikes[7]` toggles every other cycle starting at cycle 1; pulse `start` again mid-window; hold `count_ready`=0 for 5 DONE cycles → `spike_count_7`=8, the second `start` has no effect, and the counts stay stable while `count_valid` is held.
5. Assert `rst_n` low at cycle 8 of a 16-cycle window → counts are 0 and the FSM is in IDLE. A new `start` then gives a correct full-window result (`spike_count_0`=16 with `spikes[0]` held high).
6. In DONE, assert `count_ready` and `start` together → return to IDLE with counts unchanged and no new window started. A `start` on the next cycle clears the counts and begins COUNT.
